reg_file_mp: RTL and testbench

REG_FILE_MP -- requirements
Module: reg_file_mp

---
 rtl/reg_file_pkg.sv | 21 ++
 rtl/reg_file_rd_port.sv | 60 ++++++
 rtl/reg_file_mp.sv | 107 ++++++++++
 tb/tb_reg_file_mp.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port register file: FSM encodings and
// the elaboration-time log2 helper used to size address fields.
package reg_file_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: decode, write-first bypass, zero/out-of-range
// masking and the output data/valid registers.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  state_e            state,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_fire,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] mem [DEPTH],
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              in_range;
    logic              hit_zero;

    always_comb begin
        in_range   = int'(rd_addr) < DEPTH;
        hit_zero   = (ZERO_REG != 0) && (rd_addr == '0);
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (state == ST_RUN && rd_en) begin
            rd_valid_d = 1'b1;
            // Masking wins over bypass so register 0 stays zero even when written this cycle.
            if (!in_range || hit_zero) begin
                rd_data_d = '0;
            end else if (wr_fire && wr_addr == rd_addr) begin
                rd_data_d = wr_data;
            end else begin
                rd_data_d = mem[rd_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a post-reset clearing sequence; owns the
// storage array, the write path and the INIT/RUN state machine.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic                     ready
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              ready_q, ready_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              wr_fire;

    assign wr_fire = (state_q == ST_RUN) && wr_en && (int'(wr_addr) < DEPTH)
                     && !((ZERO_REG != 0) && (wr_addr == '0));

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ready_d    = ready_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;
        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = init_cnt_q;
                mem_wdata  = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d    = ST_RUN;
                    ready_d    = 1'b1;
                    init_cnt_d = '0;
                end
            end
            ST_RUN: begin
                mem_we = wr_fire;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ready_q    <= ready_d;
        end
    end

    // Array is never reset directly; contents are cleared by the INIT sweep.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        reg_file_rd_port #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_rd_port (
            .clk     (clk),
            .rst_n   (rst_n),
            .state   (state_q),
            .rd_en   (rd_en[i]),
            .rd_addr (rd_addr[i*ADDR_W +: ADDR_W]),
            .wr_fire (wr_fire),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .mem     (mem_q),
            .rd_data (rd_data[i*DATA_W +: DATA_W]),
            .rd_valid(rd_valid[i])
        );
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: a DEPTH=32 instance and a DEPTH=20 instance
// share the same stimulus so the non-power-of-two range handling is exercised.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_valid_a, rd_valid_b;
    logic        ready_a, ready_b;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] acc;
    logic [1:0]  vacc;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .ready(ready_a)
    );

    reg_file_mp #(.DATA_W(32), .DEPTH(20), .NUM_RD(2), .ZERO_REG(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .ready(ready_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        rd_en = 2'b00;
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;
        repeat (3) step();
        check("rst_ready", {ready_b, ready_a}, 64'd0);
        check("rst_rd_data", rd_data_a, 64'd0);
        check("rst_rd_valid", rd_valid_a, 64'd0);

        rst_n = 1'b1;
        for (int n = 1; n <= 32; n++) begin
            step();
            if (n == 19 || n == 20) check($sformatf("ready_b_edge%0d", n), ready_b, (n == 20));
            if (n == 31 || n == 32) check($sformatf("ready_a_edge%0d", n), ready_a, (n == 32));
        end

        acc  = '0;
        vacc = 2'b11;
        for (int i = 0; i < 16; i++) begin
            rd_en   = 2'b11;
            rd_addr = {5'(i + 16), 5'(i)};
            step();
            acc  = acc | rd_data_a;
            vacc = vacc & rd_valid_a;
        end
        idle();
        check("init_all_zero", acc, 64'd0);
        check("init_all_valid", vacc, 64'd3);

        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h2D8E;
        step();
        wr_en = 1'b0; rd_en = 2'b11; rd_addr = {5'd1, 5'd1};
        step();
        rd_en = 2'b00;
        check("rd_both_data", rd_data_a, {32'h2D8E, 32'h2D8E});
        check("rd_both_valid", rd_valid_a, 64'd3);
        step();
        check("hold_valid", rd_valid_a, 64'd0);
        check("hold_data", rd_data_a, {32'h2D8E, 32'h2D8E});

        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h3BE2;
        rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
        step();
        idle();
        check("bypass_p0_data", rd_data_a, {32'h2D8E, 32'h3BE2});
        check("bypass_p0_valid", rd_valid_a, 64'd1);

        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h5A5A_5A5A;
        rd_en = 2'b11; rd_addr = {5'd5, 5'd5};
        step();
        idle();
        check("bypass_both_a", rd_data_a, {32'h5A5A_5A5A, 32'h5A5A_5A5A});
        check("bypass_both_b", rd_data_b, {32'h5A5A_5A5A, 32'h5A5A_5A5A});

        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        step();
        wr_en = 1'b0; rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
        step();
        check("zero_reg_read", rd_data_a, 64'd0);
        check("zero_reg_valid", rd_valid_a, 64'd3);
        step();
        idle();
        step();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        rd_en = 2'b11; rd_addr = {5'd0, 5'd0};
        step();
        idle();
        check("zero_reg_bypass", rd_data_a, 64'd0);

        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h1330;
        step();
        wr_en = 1'b0; rd_en = 2'b10; rd_addr = {5'd9, 5'd0};
        step();
        idle();
        check("pre_rst_reg9", rd_data_a, {32'h1330, 32'h0});

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrun_rst_ready", ready_a, 64'd0);
        check("midrun_rst_data", rd_data_a, 64'd0);
        check("midrun_rst_valid", rd_valid_a, 64'd0);

        acc  = '0;
        vacc = 2'b00;
        for (int n = 1; n <= 32; n++) begin
            if (n <= 19) begin
                wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hDEAD;
                rd_en = 2'b11; rd_addr = {5'd9, 5'd9};
            end else begin
                idle();
            end
            step();
            acc  = acc | rd_data_a;
            vacc = vacc | rd_valid_a;
        end
        check("init_ignores_rd_valid", vacc, 64'd0);
        check("init_ignores_rd_data", acc, 64'd0);
        check("reinit_ready", ready_a, 64'd1);

        rd_en = 2'b11; rd_addr = {5'd9, 5'd9};
        step();
        idle();
        check("reinit_reg9_a", rd_data_a, 64'd0);
        check("reinit_reg9_b", rd_data_b, 64'd0);

        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h77;
        step();
        wr_addr = 5'd25; wr_data = 32'hABCD;
        step();
        wr_en = 1'b0; rd_en = 2'b11; rd_addr = {5'd25, 5'd25};
        step();
        idle();
        check("addr25_depth32", rd_data_a, {32'hABCD, 32'hABCD});
        check("oor_read_data", rd_data_b, 64'd0);
        check("oor_read_valid", rd_valid_b, 64'd3);

        for (int i = 0; i < 10; i++) begin
            rd_en   = 2'b11;
            rd_addr = {5'(i + 10), 5'(i)};
            step();
            check($sformatf("depth20_entry%0d_%0d", i, i + 10), rd_data_b,
                  {32'h0, (i == 5) ? 32'h77 : 32'h0});
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
